ema_ctrl: RTL and testbench



---
 rtl/ema_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ema_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ema_ctrl.sv
// Exponential moving average controller: y[n] = a*x[n] + (1-a)*y[n-1] in Q1.AFRAC,
// sequenced over a shared single-cycle-latency ALU with a fixed 6-cycle schedule.
module ema_ctrl #(
  parameter int unsigned Win   = 16,
  parameter int unsigned Wout  = 32,
  parameter int unsigned AFRAC = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [Win-1:0]  x_i,
  input  logic                   x_valid_i,
  output logic                   x_ready_o,
  input  logic signed [Win:0]    alpha_i,
  output logic signed [Win-1:0]  alu_op1_o,
  output logic signed [Win:0]    alu_op2_o,
  output logic [1:0]             alu_mode_o,
  output logic                   alu_valid_o,
  input  logic signed [Wout-1:0] alu_res_i,
  input  logic                   alu_valid_i,
  output logic signed [Win-1:0]  y_o,
  output logic                   y_valid_o,
  output logic                   err_o
);

  localparam logic [1:0] ModeIdle = 2'd0;
  localparam logic [1:0] ModeAdd  = 2'd1;
  localparam logic [1:0] ModeMult = 2'd2;

  localparam logic signed [Win:0]   AlphaOne = (Win+1)'(2**AFRAC);
  localparam logic signed [Win-1:0] YMax     = {1'b0, {(Win-1){1'b1}}};
  localparam logic signed [Win-1:0] YMin     = {1'b1, {(Win-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMulA, StMulB, StCapB, StAdd, StDone} state_e;

  state_e r_state, w_state_next;

  logic signed [Win-1:0] r_x, r_pa, r_pb, r_y;
  logic signed [Win:0]   r_alpha;
  logic                  r_y_valid, r_err;

  logic                  w_handshake;
  logic signed [Win:0]   w_alpha_clamped;
  logic signed [Wout-1:0] w_res_shr;
  logic signed [Win-1:0] w_prod;
  logic signed [Win:0]   w_sum;
  logic signed [Win-1:0] w_sum_sat;
  logic                  w_alu_chk;
  logic                  w_unused;

  assign w_handshake = x_valid_i && (r_state == StIdle);

  always_comb begin
    if (alpha_i[Win]) begin
      w_alpha_clamped = '0;
    end else if (alpha_i > AlphaOne) begin
      w_alpha_clamped = AlphaOne;
    end else begin
      w_alpha_clamped = alpha_i;
    end
  end

  // Arithmetic shift floors toward -inf; only the low Win bits are kept.
  assign w_res_shr = alu_res_i >>> AFRAC;
  assign w_prod    = w_res_shr[Win-1:0];
  assign w_unused  = ^w_res_shr[Wout-1:Win];

  assign w_sum = alu_res_i[Win:0];

  always_comb begin
    if (w_sum[Win] != w_sum[Win-1]) begin
      w_sum_sat = w_sum[Win] ? YMin : YMax;
    end else begin
      w_sum_sat = w_sum[Win-1:0];
    end
  end

  // States that consume an ALU result expect alu_valid_i from the previous issue.
  assign w_alu_chk = (r_state == StMulB) || (r_state == StCapB) || (r_state == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (x_valid_i) w_state_next = StMulA;
      StMulA:  w_state_next = StMulB;
      StMulB:  w_state_next = StCapB;
      StCapB:  w_state_next = StAdd;
      StAdd:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    alu_op1_o   = '0;
    alu_op2_o   = '0;
    alu_mode_o  = ModeIdle;
    alu_valid_o = 1'b0;
    unique case (r_state)
      StMulA: begin
        alu_op1_o   = r_x;
        alu_op2_o   = r_alpha;
        alu_mode_o  = ModeMult;
        alu_valid_o = 1'b1;
      end
      StMulB: begin
        alu_op1_o   = r_y;
        alu_op2_o   = AlphaOne - r_alpha;
        alu_mode_o  = ModeMult;
        alu_valid_o = 1'b1;
      end
      StAdd: begin
        alu_op1_o   = r_pa;
        alu_op2_o   = {r_pb[Win-1], r_pb};
        alu_mode_o  = ModeAdd;
        alu_valid_o = 1'b1;
      end
      default: begin
        alu_op1_o   = '0;
        alu_op2_o   = '0;
        alu_mode_o  = ModeIdle;
        alu_valid_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_alpha   <= '0;
      r_pa      <= '0;
      r_pb      <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_x     <= x_i;
        r_alpha <= w_alpha_clamped;
      end
      if (r_state == StMulB) r_pa <= w_prod;
      if (r_state == StCapB) r_pb <= w_prod;
      if (r_state == StDone) r_y  <= w_sum_sat;
      r_y_valid <= (r_state == StDone);
      if (w_alu_chk && !alu_valid_i) r_err <= 1'b1;
    end
  end

  assign x_ready_o = (r_state == StIdle);
  assign y_o       = r_y;
  assign y_valid_o = r_y_valid;
  assign err_o     = r_err;

endmodule

// File: tb/tb_ema_ctrl.sv
// Self-checking bench for ema_ctrl: table of directed samples plus hand-written
// sequences for back-to-back valid, reset mid-flight, missing ALU valid and saturation.
module tb_ema_ctrl;

  logic               clk;
  logic               rst;
  logic signed [15:0] x_i;
  logic               x_valid_i;
  logic               x_ready_o;
  logic signed [16:0] alpha_i;
  logic signed [15:0] alu_op1_o;
  logic signed [16:0] alu_op2_o;
  logic [1:0]         alu_mode_o;
  logic               alu_valid_o;
  logic signed [31:0] alu_res_i;
  logic               alu_valid_i;
  logic signed [15:0] y_o;
  logic               y_valid_o;
  logic               err_o;

  int n_checks = 0;
  int n_errors = 0;

  // ALU model controls: drop the valid, or replace the result for one issue.
  logic               tb_kill;
  logic               tb_force;
  logic signed [31:0] tb_res_val;
  logic signed [31:0] w_a, w_b, w_model;

  ema_ctrl #(.Win(16), .Wout(32), .AFRAC(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .x_i         (x_i),
    .x_valid_i   (x_valid_i),
    .x_ready_o   (x_ready_o),
    .alpha_i     (alpha_i),
    .alu_op1_o   (alu_op1_o),
    .alu_op2_o   (alu_op2_o),
    .alu_mode_o  (alu_mode_o),
    .alu_valid_o (alu_valid_o),
    .alu_res_i   (alu_res_i),
    .alu_valid_i (alu_valid_i),
    .y_o         (y_o),
    .y_valid_o   (y_valid_o),
    .err_o       (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    w_a = alu_op1_o;
    w_b = alu_op2_o;
    case (alu_mode_o)
      2'd1:    w_model = w_a + w_b;
      2'd2:    w_model = w_a * w_b;
      default: w_model = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_i   <= '0;
      alu_valid_i <= 1'b0;
    end else begin
      alu_res_i   <= tb_force ? tb_res_val : w_model;
      alu_valid_i <= alu_valid_o && !tb_kill;
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    x_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Handshake one sample, then expect the pulse exactly 6 cycles later.
  task automatic run_sample(input logic signed [15:0] x, input logic signed [16:0] a,
                            input logic signed [15:0] exp_y, input string tag);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(x_ready_o), 1);
    x_i = x;
    alpha_i = a;
    x_valid_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        chk($sformatf("%s_busy%0d", tag, k), 32'({x_ready_o, y_valid_o}), 0);
      end else begin
        chk({tag, "_yv"}, 32'(y_valid_o), 1);
        chk({tag, "_rdy6"}, 32'(x_ready_o), 1);
        chk({tag, "_y"}, y_o, exp_y);
      end
      if (k == 1) begin
        x_i = ~x;
        alpha_i = 17'sd32768;
      end
      if (k >= 5) x_valid_i = 1'b0;
    end
  endtask

  // Replace the ADD result seen in DONE to exercise output saturation.
  task automatic sat_sample(input logic signed [31:0] v, input logic signed [15:0] exp_y,
                            input string tag);
    @(negedge clk);
    x_i = '0;
    alpha_i = '0;
    x_valid_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) x_valid_i = 1'b0;
      if (k == 4) begin
        tb_force = 1'b1;
        tb_res_val = v;
      end
      if (k == 5) tb_force = 1'b0;
      if (k == 6) chk(tag, y_o, exp_y);
    end
  endtask

  typedef struct {
    bit                 do_rst;
    logic signed [15:0] x;
    logic signed [16:0] alpha;
    logic signed [15:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ph;
    vecs[0] = '{1'b1, -16'sd1,    17'sd16384,  -16'sd1};
    vecs[1] = '{1'b1, 16'sd1000,  17'sd16384,  16'sd500};
    vecs[2] = '{1'b0, 16'sd1000,  17'sd16384,  16'sd750};
    vecs[3] = '{1'b0, 16'sd1000,  17'sd16384,  16'sd875};
    vecs[4] = '{1'b0, -16'sd1234, 17'sd32768,  -16'sd1234};
    vecs[5] = '{1'b0, 16'sd5000,  17'sd0,      -16'sd1234};
    vecs[6] = '{1'b0, 16'sd321,   17'sd40000,  16'sd321};
    vecs[7] = '{1'b0, 16'sd999,   -17'sd5,     16'sd321};
    vecs[8] = '{1'b0, 16'sd2000,  17'sd8192,   16'sd740};
    vecs[9] = '{1'b0, -16'sd3000, 17'sd24576,  -16'sd2065};

    rst = 1'b1;
    x_i = '0;
    alpha_i = '0;
    x_valid_i = 1'b0;
    tb_kill = 1'b0;
    tb_force = 1'b0;
    tb_res_val = '0;

    do_reset();
    chk("rst_rdy", 32'(x_ready_o), 1);
    chk("rst_mode", 32'(alu_mode_o), 0);
    chk("rst_aluv", 32'(alu_valid_o), 0);
    chk("rst_yv", 32'(y_valid_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_y", y_o, 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) do_reset();
      run_sample(vecs[i].x, vecs[i].alpha, vecs[i].exp_y, $sformatf("v%0d", i));
    end

    // x_valid_i held high: one handshake every 6 cycles.
    @(negedge clk);
    x_i = 16'sd100;
    alpha_i = 17'sd32768;
    x_valid_i = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      ph = c % 6;
      chk($sformatf("hold%0d_rdy", c), 32'(x_ready_o), (ph == 0) ? 1 : 0);
      chk($sformatf("hold%0d_yv", c), 32'(y_valid_o), (ph == 0 && c > 0) ? 1 : 0);
      chk($sformatf("hold%0d_mode", c), 32'(alu_mode_o),
          (ph == 1 || ph == 2) ? 2 : (ph == 4) ? 1 : 0);
      chk($sformatf("hold%0d_aluv", c), 32'(alu_valid_o),
          (ph == 1 || ph == 2 || ph == 4) ? 1 : 0);
      if (ph == 0 && c > 0) chk($sformatf("hold%0d_y", c), y_o, 100);
    end
    x_valid_i = 1'b0;

    // Reset while in ADD: no pulse, registers cleared.
    @(negedge clk);
    x_i = 16'sd500;
    alpha_i = 17'sd32768;
    x_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("radd_mode", 32'(alu_mode_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("radd_yv", 32'(y_valid_o), 0);
    chk("radd_y", y_o, 0);
    chk("radd_err", 32'(err_o), 0);
    chk("radd_rdy", 32'(x_ready_o), 1);
    chk("radd_mode0", 32'(alu_mode_o), 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("radd_nopulse%0d", k), 32'(y_valid_o), 0);
    end

    // ALU valid dropped for the CAP_B capture: sticky error, sequence still completes.
    @(negedge clk);
    x_i = 16'sd700;
    alpha_i = 17'sd32768;
    x_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x_valid_i = 1'b0;
    @(negedge clk);
    chk("err_pre", 32'(err_o), 0);
    tb_kill = 1'b1;
    @(negedge clk);
    tb_kill = 1'b0;
    chk("err_capb_aluv", 32'(alu_valid_o), 0);
    @(negedge clk);
    chk("err_set", 32'(err_o), 1);
    repeat (2) @(negedge clk);
    chk("err_yv", 32'(y_valid_o), 1);
    chk("err_y", y_o, 700);
    run_sample(16'sd10, 17'sd32768, 16'sd10, "err_keep");
    chk("err_sticky", 32'(err_o), 1);
    do_reset();
    chk("err_clr", 32'(err_o), 0);

    sat_sample(32'sd40000,  16'sd32767,  "sat_pos");
    sat_sample(-32'sd40000, -16'sd32768, "sat_neg");
    sat_sample(32'sd32768,  16'sd32767,  "sat_pos_edge");
    sat_sample(-32'sd32769, -16'sd32768, "sat_neg_edge");
    sat_sample(32'sd32767,  16'sd32767,  "sat_max_in");
    sat_sample(-32'sd300,   -16'sd300,   "sat_in_range");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
